// File: rtl/nes_pad_poller_if.sv
// nes_pad_poller_if: NES connector pins plus published button state for nes_pad_poller
//   nes_data    pad -> poller, one active-low serial line per pad
//   nes_latch   poller -> pads, shared latch strobe
//   nes_pulse   poller -> pads, shared shift clock
//   buttons     held state, active-high, pad p in [8p+7:8p]
//   pressed     one-cycle press pulses, same layout as buttons
//   frame_valid one-cycle pulse when buttons updates
//   nes_reset   one-cycle reset request from the pad 0 combo
interface nes_pad_poller_if #(parameter int NUM_PADS = 1) ();
  logic [NUM_PADS-1:0]   nes_data;
  logic                  nes_latch;
  logic                  nes_pulse;
  logic [8*NUM_PADS-1:0] buttons;
  logic [8*NUM_PADS-1:0] pressed;
  logic                  frame_valid;
  logic                  nes_reset;
  modport master (input nes_data, output nes_latch, nes_pulse, buttons, pressed, frame_valid, nes_reset);
  modport slave (output nes_data, input nes_latch, nes_pulse, buttons, pressed, frame_valid, nes_reset);
endinterface

// File: rtl/nes_pad_poller.sv
// nes_pad_poller: polls NUM_PADS NES controllers, publishes held/pressed buttons and a combo reset
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    nes_pad_poller_if master side (pad pins plus button outputs)
//   Optional NES_AUTOREPEAT_EN: per-button frame hold counters re-fire pressed at 16 frames, then every 6
module nes_pad_poller #(
  parameter int NUM_PADS     = 1,
  parameter int HALF_CYCLES  = 300,
  parameter int POLL_CYCLES  = 833333,
  parameter int RESET_FRAMES = 60
) (
  input logic              clk,
  input logic              reset,
  nes_pad_poller_if.master bus
);
  localparam int CW = $clog2(2*HALF_CYCLES) > 0 ? $clog2(2*HALF_CYCLES) : 1;
  localparam int PW = $clog2(POLL_CYCLES) > 0 ? $clog2(POLL_CYCLES) : 1;
  localparam int RW = $clog2(RESET_FRAMES+1) > 0 ? $clog2(RESET_FRAMES+1) : 1;
  localparam int NB = 8*NUM_PADS;
  typedef enum logic [2:0] {IDLE, LATCH, LATCH_GAP, PULSE_HI, PULSE_LO, UPDATE} state_t;
  state_t                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d, lim;
  logic [2:0]                 bit_q, bit_d;
  logic [PW-1:0]              poll_q;
  logic [RW-1:0]              rf_q;
  logic [NUM_PADS-1:0][7:0]   sh_q;
  logic [NB-1:0]              new_b, buttons_q, pressed_q, press_d;
  logic                       frame_valid_q, nes_reset_q;
  logic                       tick, last, timed, samp, publish, combo, fire;
  assign tick  = poll_q == '0;
  assign new_b = sh_q;
  assign combo = &sh_q[0][3:0];
  assign fire  = combo && rf_q == RW'(RESET_FRAMES-1);
  // bit_q is the index of the next bit to sample; it wraps to 0 once bit 7 is in
  always_comb begin
    lim     = state_q == LATCH ? CW'(2*HALF_CYCLES-1) : CW'(HALF_CYCLES-1);
    last    = cnt_q == lim;
    timed   = state_q inside {LATCH, LATCH_GAP, PULSE_HI, PULSE_LO};
    cnt_d   = (timed && !last) ? cnt_q + 1'b1 : '0;
    samp    = last && (state_q == LATCH_GAP || state_q == PULSE_HI);
    bit_d   = samp ? bit_q + 1'b1 : bit_q;
    publish = last && state_q == PULSE_LO && bit_q == '0;
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = tick ? LATCH : IDLE;
      LATCH:     state_d = last ? LATCH_GAP : LATCH;
      LATCH_GAP: state_d = last ? PULSE_HI : LATCH_GAP;
      PULSE_HI:  state_d = last ? PULSE_LO : PULSE_HI;
      PULSE_LO:  state_d = !last ? PULSE_LO : (bit_q == '0 ? UPDATE : PULSE_HI);
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
    end
  end
`ifdef NES_AUTOREPEAT_EN
  logic [NB-1:0][3:0] hc_q, hc_d;
  // 15 -> 10 reload turns "16 frames, then every 6" into a 4-bit counter
  always_comb begin
    hc_d    = hc_q;
    press_d = '0;
    for (int i = 0; i < NB; i++) begin
      hc_d[i]    = !new_b[i] ? 4'd0 : !buttons_q[i] ? 4'd1 : hc_q[i] == 4'd15 ? 4'd10 : hc_q[i] + 4'd1;
      press_d[i] = new_b[i] && (!buttons_q[i] || hc_q[i] == 4'd15);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) hc_q <= '0;
    else if (publish) hc_q <= hc_d;
  end
`else
  assign press_d = new_b & ~buttons_q;
`endif
  // outputs are loaded on entry to UPDATE so they are visible during that cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      poll_q        <= '0;
      rf_q          <= '0;
      sh_q          <= '0;
      buttons_q     <= '0;
      pressed_q     <= '0;
      frame_valid_q <= 1'b0;
      nes_reset_q   <= 1'b0;
    end else begin
      poll_q        <= poll_q == PW'(POLL_CYCLES-1) ? '0 : poll_q + 1'b1;
      frame_valid_q <= publish;
      pressed_q     <= publish ? press_d : '0;
      nes_reset_q   <= publish && fire;
      if (samp)
        for (int p = 0; p < NUM_PADS; p++) sh_q[p][bit_q] <= ~bus.nes_data[p];
      if (publish) begin
        buttons_q <= new_b;
        rf_q      <= (combo && !fire) ? rf_q + 1'b1 : '0;
      end
    end
  end
  assign bus.nes_latch   = state_q == LATCH;
  assign bus.nes_pulse   = state_q == PULSE_HI;
  assign bus.buttons     = buttons_q;
  assign bus.pressed     = pressed_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.nes_reset   = nes_reset_q;
endmodule

// File: tb/tb_nes_pad_poller.sv
// tb_nes_pad_poller: directed checks of pad timing, deserialisation, presses, reset combo and mid-frame reset
module tb_nes_pad_poller;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pad_btn [2];
  logic [2:0] idx = '0;
  logic       pulse_d = 1'b0;
  int         n_chk = 0;
  int         n_err = 0;
  nes_pad_poller_if #(.NUM_PADS(2)) bus ();
  nes_pad_poller #(.NUM_PADS(2), .HALF_CYCLES(4), .POLL_CYCLES(200), .RESET_FRAMES(3)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  // pad model: latch reloads, each pulse rising edge shifts to the next button
  always @(posedge clk) begin
    pulse_d <= bus.nes_pulse;
    if (bus.nes_latch) idx <= '0;
    else if (bus.nes_pulse && !pulse_d) idx <= idx + 1'b1;
  end
  always_comb for (int p = 0; p < 2; p++) bus.nes_data[p] = ~pad_btn[p][idx];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic next_frame(input logic [7:0] b0, input logic [7:0] b1);
    int n;
    pad_btn[0] = b0;
    pad_btn[1] = b1;
    n = 0;
    @(negedge clk);
    while (!bus.frame_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!bus.frame_valid) check("frame_timeout", 32'd0, 32'd1);
  endtask
  initial begin
    int lat_n, lat_first, rises, hi_n, fv_k, fv_n, n;
    logic prev;
    pad_btn[0] = 8'h81;
    pad_btn[1] = 8'h08;
    repeat (5) @(negedge clk);
    check("rst_outs", {bus.nes_latch, bus.nes_pulse, bus.frame_valid, bus.nes_reset}, 32'h0);
    check("rst_buttons", bus.buttons, 32'h0);
    check("rst_pressed", bus.pressed, 32'h0);
    reset = 1'b0;
    lat_n = 0; lat_first = 0; rises = 0; hi_n = 0; fv_k = 0; fv_n = 0; prev = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (bus.nes_latch) begin
        lat_n++;
        if (lat_first == 0) lat_first = k;
      end
      if (bus.nes_pulse) hi_n++;
      if (bus.nes_pulse && !prev) rises++;
      prev = bus.nes_pulse;
      if (bus.frame_valid) begin
        fv_n++;
        fv_k = k;
        check("f1_buttons", bus.buttons, 32'h0881);
        check("f1_pressed", bus.pressed, 32'h0881);
      end
    end
    check("latch_first", lat_first, 1);
    check("latch_len", lat_n, 8);
    check("pulse_count", rises, 7);
    check("pulse_hi_len", hi_n, 28);
    check("fv_clock", fv_k, 69);
    check("fv_count", fv_n, 1);
    next_frame(8'h81, 8'h08);
    check("f2_buttons", bus.buttons, 32'h0881);
    check("f2_pressed", bus.pressed, 32'h0);
    next_frame(8'h80, 8'h08);
    check("rel_buttons", bus.buttons, 32'h0880);
    check("rel_pressed", bus.pressed, 32'h0);
    next_frame(8'h81, 8'h08);
    check("repress_buttons", bus.buttons, 32'h0881);
    check("repress_pressed", bus.pressed, 32'h0001);
    @(negedge clk);
    check("pressed_one_cycle", bus.pressed, 32'h0);
    check("fv_one_cycle", bus.frame_valid, 32'h0);
    next_frame(8'h0F, 8'h00);
    check("combo_buttons", bus.buttons, 32'h000F);
    check("combo_a1", bus.nes_reset, 0);
    next_frame(8'h0F, 8'h00);
    check("combo_a2", bus.nes_reset, 0);
    next_frame(8'h00, 8'h00);
    check("combo_drop", bus.nes_reset, 0);
    next_frame(8'h0F, 8'h00);
    check("combo_b1", bus.nes_reset, 0);
    next_frame(8'h0F, 8'h00);
    check("combo_b2", bus.nes_reset, 0);
    next_frame(8'h0F, 8'h00);
    check("combo_b3", bus.nes_reset, 1);
    @(negedge clk);
    check("combo_pulse_len", bus.nes_reset, 0);
    next_frame(8'h0F, 8'h00);
    check("combo_c1", bus.nes_reset, 0);
    pad_btn[0] = 8'h81;
    pad_btn[1] = 8'h08;
    n = 0;
    while (!bus.nes_pulse && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("pulse_seen", bus.nes_pulse, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_latch_pulse", {bus.nes_latch, bus.nes_pulse}, 32'h0);
    check("mid_buttons", bus.buttons, 32'h0);
    check("mid_fv", bus.frame_valid, 0);
    reset = 1'b0;
    fv_k = 0;
    fv_n = 0;
    for (int k = 1; k <= 75; k++) begin
      @(negedge clk);
      if (bus.frame_valid) begin
        fv_n++;
        fv_k = k;
      end
    end
    check("mid_fv_clock", fv_k, 69);
    check("mid_fv_count", fv_n, 1);
    check("mid_new_buttons", bus.buttons, 32'h0881);
    next_frame(8'h00, 8'h00);
    for (int f = 1; f <= 30; f++) begin
      next_frame(8'h40, 8'h00);
`ifdef NES_AUTOREPEAT_EN
      check($sformatf("left_f%0d", f), bus.pressed[6], (f == 1 || f == 16 || f == 22 || f == 28) ? 1 : 0);
`else
      check($sformatf("left_f%0d", f), bus.pressed[6], (f == 1) ? 1 : 0);
`endif
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
